// File: rtl/fifo_fwft_if.sv
// Handshake bundle between a FIFO and its producer/consumer logic.
// The slave modport is the FIFO side; the master modport is the user side.
interface fifo_fwft_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] din;
    logic                  wr_en;
    logic                  full;
    logic                  almost_full;
    logic [DATA_WIDTH-1:0] dout;
    logic                  rd_en;
    logic                  dout_valid;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   elemcnt;
    logic                  overflow;
    logic                  underflow;

    modport slave (
        input  din, wr_en, rd_en,
        output full, almost_full, dout, dout_valid, empty, almost_empty,
               elemcnt, overflow, underflow
    );

    modport master (
        output din, wr_en, rd_en,
        input  full, almost_full, dout, dout_valid, empty, almost_empty,
               elemcnt, overflow, underflow
    );
endinterface

// File: rtl/fifo_fwft.sv
// Synchronous FIFO with standard or first-word-fall-through read mode,
// full 2^ADDR_WIDTH depth, programmable almost flags and sticky error flags.
module fifo_fwft #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int FWFT         = 0,
    parameter int AFULL_LEVEL  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic        clk,
    input  logic        rst,
    fifo_fwft_if.slave  fifo
);
    localparam int                  DEPTH     = 1 << ADDR_WIDTH;
    localparam int                  PW        = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L   = PW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_L   = PW'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_L  = PW'(AEMPTY_LEVEL);
    localparam bit                  FWFT_MODE = (FWFT != 0);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wrptr_q, wrptr_d;
    logic [ADDR_WIDTH:0]   rdptr_q, rdptr_d;
    logic [ADDR_WIDTH:0]   count;
    logic                  full_w;
    logic                  wr_ok, rd_ok;
    logic                  empty_q, empty_d;
    logic                  rd_pend_q;
    logic                  dout_valid_q;
    logic                  overflow_q, underflow_q;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] dout_q;

    always_comb begin
        count   = wrptr_q - rdptr_q;
        full_w  = (count == DEPTH_L);
        wr_ok   = fifo.wr_en && !full_w;
        rd_ok   = fifo.rd_en && !empty_q;
        wrptr_d = wrptr_q + PW'(wr_ok);
        rdptr_d = rdptr_q + PW'(rd_ok);
        // Current write pointer against next read pointer: a pop takes effect
        // at once, while a new word only becomes readable one edge later.
        empty_d = (wrptr_q == rdptr_d);
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wrptr_q[ADDR_WIDTH-1:0]] <= fifo.din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr_q      <= '0;
            rdptr_q      <= '0;
            empty_q      <= 1'b1;
            rd_pend_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            ram_q        <= '0;
            dout_q       <= '0;
        end else begin
            wrptr_q     <= wrptr_d;
            rdptr_q     <= rdptr_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_q  | (fifo.wr_en && full_w);
            underflow_q <= underflow_q | (fifo.rd_en && empty_q);
            if (FWFT_MODE) begin
                // Prefetch the head word from the next read address.
                if (!empty_d) begin
                    ram_q <= mem[rdptr_d[ADDR_WIDTH-1:0]];
                end
            end else begin
                if (rd_ok) begin
                    ram_q <= mem[rdptr_q[ADDR_WIDTH-1:0]];
                end
                rd_pend_q    <= rd_ok;
                dout_valid_q <= rd_pend_q;
                if (rd_pend_q) begin
                    dout_q <= ram_q;
                end
            end
        end
    end

    assign fifo.full         = full_w;
    assign fifo.almost_full  = (count >= AFULL_L);
    assign fifo.almost_empty = (count <= AEMPTY_L);
    assign fifo.elemcnt      = count;
    assign fifo.empty        = empty_q;
    assign fifo.dout         = FWFT_MODE ? ram_q : dout_q;
    assign fifo.dout_valid   = FWFT_MODE ? !empty_q : dout_valid_q;
    assign fifo.overflow     = overflow_q;
    assign fifo.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_fwft.sv
// Directed and model-checked bench for fifo_fwft in standard and FWFT modes.
module tb_fifo_fwft;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_fwft_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) s_if ();
    fifo_fwft_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) f_if ();

    fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) u_std (
        .clk  (clk),
        .rst  (rst),
        .fifo (s_if.slave)
    );

    fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) u_fwft (
        .clk  (clk),
        .rst  (rst),
        .fifo (f_if.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.din = 8'h00;
        f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.din = 8'h00;
    endtask

    task automatic check_std_reset(input string p);
        check({p, "_elemcnt"},  32'(s_if.elemcnt), 32'd0);
        check({p, "_empty"},    32'(s_if.empty), 32'd1);
        check({p, "_aempty"},   32'(s_if.almost_empty), 32'd1);
        check({p, "_full"},     32'(s_if.full), 32'd0);
        check({p, "_afull"},    32'(s_if.almost_full), 32'd0);
        check({p, "_dvalid"},   32'(s_if.dout_valid), 32'd0);
        check({p, "_dout"},     32'(s_if.dout), 32'd0);
        check({p, "_overflow"}, 32'(s_if.overflow), 32'd0);
        check({p, "_underflow"},32'(s_if.underflow), 32'd0);
    endtask

    task automatic do_reset;
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] q[$];

    initial begin
        idle_all();
        rst = 1'b1;
        tick();
        tick();
        check_std_reset("rst0");
        check("rst0_f_empty", 32'(f_if.empty), 32'd1);
        check("rst0_f_dvalid", 32'(f_if.dout_valid), 32'd0);
        check("rst0_f_dout", 32'(f_if.dout), 32'd0);
        rst = 1'b0;

        // Fill the standard FIFO with 0x01..0x10, then one write too many.
        for (int i = 1; i <= 16; i++) begin
            s_if.wr_en = 1'b1;
            s_if.din   = 8'(i);
            tick();
            check("fill_elemcnt", 32'(s_if.elemcnt), 32'(i));
            check("fill_afull", 32'(s_if.almost_full), (i >= 14) ? 32'd1 : 32'd0);
            check("fill_full", 32'(s_if.full), (i == 16) ? 32'd1 : 32'd0);
        end
        s_if.din = 8'h77;
        tick();
        s_if.wr_en = 1'b0;
        check("ovf_flag", 32'(s_if.overflow), 32'd1);
        check("ovf_elemcnt", 32'(s_if.elemcnt), 32'd16);

        // Read and write together while full: read wins, write dropped.
        s_if.rd_en = 1'b1; s_if.wr_en = 1'b1; s_if.din = 8'h88;
        tick();
        s_if.rd_en = 1'b0; s_if.wr_en = 1'b0;
        check("fullrw_elemcnt", 32'(s_if.elemcnt), 32'd15);
        tick();
        check("fullrw_dvalid", 32'(s_if.dout_valid), 32'd1);
        check("fullrw_dout", 32'(s_if.dout), 32'h01);
        check("fullrw_ovf", 32'(s_if.overflow), 32'd1);

        for (int j = 0; j <= 15; j++) begin
            s_if.rd_en = (j < 15);
            tick();
            check("drain_dvalid", 32'(s_if.dout_valid), (j >= 1) ? 32'd1 : 32'd0);
            if (j >= 1) check("drain_dout", 32'(s_if.dout), 32'(j + 1));
        end
        s_if.rd_en = 1'b0;
        check("drain_elemcnt", 32'(s_if.elemcnt), 32'd0);
        check("drain_empty", 32'(s_if.empty), 32'd1);
        check("drain_udf", 32'(s_if.underflow), 32'd0);

        // Three words, rd_en held for four cycles.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            s_if.wr_en = 1'b1;
            s_if.din   = 8'(i);
            tick();
        end
        s_if.wr_en = 1'b0;
        for (int j = 0; j <= 4; j++) begin
            s_if.rd_en = (j < 4);
            tick();
            check("rd3_dvalid", 32'(s_if.dout_valid), (j >= 1 && j <= 3) ? 32'd1 : 32'd0);
            if (j >= 1 && j <= 3) check("rd3_dout", 32'(s_if.dout), 32'(j));
            check("rd3_udf", 32'(s_if.underflow), (j >= 3) ? 32'd1 : 32'd0);
        end
        s_if.rd_en = 1'b0;
        check("rd3_hold", 32'(s_if.dout), 32'h03);

        // FWFT: single word into an empty FIFO.
        f_if.wr_en = 1'b1; f_if.din = 8'hA5;
        tick();
        f_if.wr_en = 1'b0;
        check("a5_empty_k", 32'(f_if.empty), 32'd1);
        check("a5_elemcnt_k", 32'(f_if.elemcnt), 32'd1);
        tick();
        check("a5_empty_k1", 32'(f_if.empty), 32'd0);
        check("a5_dout_k1", 32'(f_if.dout), 32'hA5);
        check("a5_dvalid_k1", 32'(f_if.dout_valid), 32'd1);
        tick();
        check("a5_dout_k2", 32'(f_if.dout), 32'hA5);
        f_if.rd_en = 1'b1;
        tick();
        f_if.rd_en = 1'b0;
        check("a5_empty_pop", 32'(f_if.empty), 32'd1);
        check("a5_dvalid_pop", 32'(f_if.dout_valid), 32'd0);
        check("a5_elemcnt_pop", 32'(f_if.elemcnt), 32'd0);
        check("a5_udf", 32'(f_if.underflow), 32'd0);

        // FWFT: back-to-back pops with no bubbles.
        for (int i = 0; i < 4; i++) begin
            f_if.wr_en = 1'b1;
            f_if.din   = 8'(8'h10 + i);
            tick();
        end
        f_if.wr_en = 1'b0;
        tick();
        for (int j = 0; j < 4; j++) begin
            check("burst_dout", 32'(f_if.dout), 32'(8'h10 + j));
            check("burst_empty", 32'(f_if.empty), 32'd0);
            f_if.rd_en = 1'b1;
            tick();
        end
        f_if.rd_en = 1'b0;
        check("burst_end_empty", 32'(f_if.empty), 32'd1);

        // FWFT: half full, simultaneous read/write for 100 cycles.
        q.delete();
        for (int i = 0; i < 8; i++) begin
            f_if.wr_en = 1'b1;
            f_if.din   = 8'(8'h20 + i);
            q.push_back(8'(8'h20 + i));
            tick();
        end
        f_if.wr_en = 1'b0;
        tick();
        for (int i = 0; i < 100; i++) begin
            check("half_dout", 32'(f_if.dout), 32'(q[0]));
            f_if.rd_en = 1'b1;
            f_if.wr_en = 1'b1;
            f_if.din   = 8'(8'h28 + i);
            tick();
            void'(q.pop_front());
            q.push_back(8'(8'h28 + i));
            check("half_elemcnt", 32'(f_if.elemcnt), 32'd8);
        end
        idle_all();

        // FWFT: random stream against a queue model.
        do_reset();
        q.delete();
        begin
            int written = 0;
            int cycles  = 0;
            int wp = 50;
            int rp = 50;
            int last_wr = 0;
            while ((written < 1000 || q.size() > 0) && cycles < 20000) begin
                bit wr, rd, model_empty, wr_ok, rd_ok;
                logic [7:0] d;
                if (cycles % 100 == 0) begin
                    wp = $urandom_range(10, 90);
                    rp = $urandom_range(10, 90);
                end
                wr = (written < 1000) && ($urandom_range(0, 99) < wp);
                rd = ($urandom_range(0, 99) < rp);
                d  = 8'($urandom_range(0, 255));
                model_empty = ((int'(q.size()) - last_wr) == 0);
                check("rnd_empty", 32'(f_if.empty), 32'(model_empty));
                check("rnd_elemcnt", 32'(f_if.elemcnt), 32'(q.size()));
                check("rnd_le16", 32'(f_if.elemcnt <= 5'd16), 32'd1);
                wr_ok = wr && (q.size() < 16);
                rd_ok = rd && !model_empty;
                if (rd_ok) check("rnd_dout", 32'(f_if.dout), 32'(q[0]));
                f_if.wr_en = wr;
                f_if.rd_en = rd;
                f_if.din   = d;
                tick();
                if (rd_ok) void'(q.pop_front());
                if (wr_ok) begin
                    q.push_back(d);
                    written++;
                end
                last_wr = wr_ok ? 1 : 0;
                cycles++;
            end
            check("rnd_done", 32'((q.size() == 0) && (written == 1000)), 32'd1);
        end
        idle_all();

        // Standard: reset with 9 words stored and both error flags set.
        do_reset();
        s_if.rd_en = 1'b1;
        tick();
        s_if.rd_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            s_if.wr_en = 1'b1;
            s_if.din   = 8'(8'h30 + i);
            tick();
        end
        s_if.wr_en = 1'b0;
        s_if.rd_en = 1'b1;
        repeat (7) tick();
        s_if.rd_en = 1'b0;
        tick();
        tick();
        check("pre_elemcnt", 32'(s_if.elemcnt), 32'd9);
        check("pre_flags", 32'({s_if.overflow, s_if.underflow}), 32'd3);
        rst = 1'b1;
        tick();
        check_std_reset("rst1");
        rst = 1'b0;
        s_if.wr_en = 1'b1; s_if.din = 8'h5A;
        tick();
        s_if.wr_en = 1'b0;
        tick();
        s_if.rd_en = 1'b1;
        tick();
        s_if.rd_en = 1'b0;
        tick();
        check("post_dvalid", 32'(s_if.dout_valid), 32'd1);
        check("post_dout", 32'(s_if.dout), 32'h5A);
        check("post_elemcnt", 32'(s_if.elemcnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_fwft.md
Name: fifo_fwft

Overview:
- Parametrised successor to the team's simple synchronous FIFO, for buffering command and data streams between single-clock-domain blocks.
- Adds the following to the basic FIFO:
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - full 2^ADDR_WIDTH usable depth, using an extra pointer bit;
  - programmable almost-full and almost-empty flags;
  - sticky overflow and underflow error flags;
  - a correctly sized fill count.

Parameters:
- DATA_WIDTH, 8: width of one data word.
- ADDR_WIDTH, 4: log2 of depth. DEPTH = 1 << ADDR_WIDTH words.
- FWFT, 0: 0 = standard mode, 1 = first-word-fall-through mode.
- AFULL_LEVEL, DEPTH-2: almost_full asserts when elemcnt >= AFULL_LEVEL.
- AEMPTY_LEVEL, 2: almost_empty asserts when elemcnt <= AEMPTY_LEVEL.

Ports:
- clk  in  1  clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- full  out  1  asserted when elemcnt == DEPTH.
- almost_full  out  1  asserted when elemcnt >= AFULL_LEVEL.
- dout  out  DATA_WIDTH  read data.
- rd_en  in  1  read request. In FWFT mode this is a pop/acknowledge.
- dout_valid  out  1  standard mode: one-cycle pulse marking read data on dout. FWFT mode: equals !empty.
- empty  out  1  no word is readable.
- almost_empty  out  1  asserted when elemcnt <= AEMPTY_LEVEL.
- elemcnt  out  ADDR_WIDTH+1  number of words written and not yet popped. Range 0..DEPTH.
- overflow  out  1  sticky; set when wr_en is high while full is high.
- underflow  out  1  sticky; set when rd_en is high while empty is high.

Behaviour:
- Reset:
  - One clock with rst high is a full reset. Reset mid-operation discards all stored words.
  - Pointers = 0, elemcnt = 0, empty = 1, almost_empty = 1, full = 0.
  - almost_full = 0, unless AFULL_LEVEL == 0.
  - dout_valid = 0, overflow = 0, underflow = 0, dout = 0.
  - RAM contents are not cleared.
- Accept rules:
  - A write is accepted when wr_en && !full. A read is accepted when rd_en && !empty.
  - full and empty are the values present in the same cycle as the request.
  - Rejected requests do not change state, apart from setting the sticky error flags.
- Simultaneous read and write:
  - When both are accepted, elemcnt is unchanged and both pointers advance.
  - When full, the read is accepted and the write is rejected; overflow is set.
  - When empty, the write is accepted and the read is rejected; underflow is set.
- Pointers and count:
  - Read and write pointers are ADDR_WIDTH+1 bits wide and wrap modulo 2*DEPTH.
  - elemcnt = wrptr - rdptr, taken modulo 2^(ADDR_WIDTH+1).
  - full is combinational from the pointers.
  - almost_full and almost_empty are combinational from elemcnt.
- Write visibility: a word written at edge k is never observable on dout before edge k+1. empty deasserts no earlier than edge k+1.
- Standard mode (FWFT=0):
  - empty is registered from the pointer state.
  - A read accepted at edge k places the word on dout after edge k+1, with dout_valid high for exactly that one cycle.
  - dout holds its value otherwise.
  - Holding rd_en high gives one word per cycle until empty.
- FWFT mode (FWFT=1):
  - When empty = 0, dout already holds the oldest word.
  - A pop at edge k presents the next word after edge k, if one was written at edge k-1 or earlier. Otherwise empty = 1 after edge k.
  - A word written to an empty FIFO at edge k appears on dout, with empty = 0, after edge k+1.
  - Sustained rd_en gives one word per cycle with no bubbles.
  - elemcnt includes the word presented on dout.
- Implementation: RAM is inferred with a synchronous read port. In FWFT mode the RAM read address is the next read pointer, so throughput is maintained.
- Error flags: overflow and underflow are cleared only by rst.

Test Plan:
- Reset, then write 0x01..0x10 on consecutive cycles (ADDR_WIDTH=4):
  - required: full = 1 after the 16th write and elemcnt = 16;
  - required: almost_full = 1 from elemcnt = 14;
  - then a 17th write: required overflow = 1 and the stored data is unchanged.
- FWFT=0, FIFO holding 3 words, rd_en held high for 4 cycles:
  - required: dout_valid pulses 3 times with 0x01, 0x02, 0x03, each one cycle after its accepted read;
  - required: 4th request gives underflow = 1 and no dout_valid pulse.
- FWFT=1, single write of 0xA5 at edge k into an empty FIFO:
  - required: dout = 0xA5 and empty = 0 from edge k+1;
  - a pop at edge k+3 gives empty = 1 after edge k+3.
- Simultaneous read and write:
  - full FIFO, rd_en && wr_en: required elemcnt stays 16 then drops to 15, oldest word read, overflow = 1;
  - half-full FIFO: required elemcnt unchanged for 100 cycles and data order preserved.
- Pointer wrap-around: stream 1000 random words at random wr_en/rd_en duty cycles -> required order matches a reference model and elemcnt never exceeds 16.
- Reset asserted with 9 words stored and both flags set -> required all outputs at reset values after one clock, and the next write/read returns the new data only.
